// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline latch enable/flush sequencing with halt and stall counter
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             mem_req,
    input  logic             dhit,
    input  logic             redirect,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {SETTLE, RUN, HALTED} state_t;

    state_t state;
    logic   dstall;
    logic   luse;

    assign dstall = mem_req & ~dhit;
    assign luse   = ex_memread & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        case (state)
            SETTLE: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
            end
            RUN: begin
                // A halting instruction in WB freezes everything; otherwise a pending dcache miss
                // holds EX/MEM so a redirect sitting there is replayed once dhit arrives.
                if (wb_halt) begin
                end else if (dstall) begin
                    memwb_flush = 1'b1;
                end else if (redirect) begin
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (luse) begin
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_flush = 1'b1;
                end else if (!ihit) begin
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                    idex_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= SETTLE;
            halt      <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                SETTLE: state <= RUN;
                RUN: begin
                    if (wb_halt) begin
                        state <= HALTED;
                        halt  <= 1'b1;
                    end else if (dstall && (stall_cnt != {CNT_W{1'b1}})) begin
                        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                HALTED: state <= HALTED;
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int EW    = 9 + 1 + CNT_W;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] C_FLUSH  = 9'b0_0_1_0_1_0_1_0_1;
    localparam logic [8:0] C_NORM   = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_DSTALL = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] C_REDIR  = 9'b1_0_1_0_1_1_0_1_0;
    localparam logic [8:0] C_LUSE   = 9'b0_0_0_0_1_1_0_1_0;
    localparam logic [8:0] C_FETCH  = 9'b0_0_1_1_0_1_0_1_0;
    localparam logic [8:0] C_ZERO   = 9'b0_0_0_0_0_0_0_0_0;

    typedef struct {
        logic       ihit, mem_req, dhit, redirect, ex_memread, wb_halt;
        logic [4:0] ex_rd, id_rs1, id_rs2;
        logic [EW-1:0] exp;
    } vec_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic ihit = 1'b0, mem_req = 1'b0, dhit = 1'b0, redirect = 1'b0, ex_memread = 1'b0, wb_halt = 1'b0;
    logic [4:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic halt;
    logic [CNT_W-1:0] stall_cnt;

    logic [EW-1:0] sb[$];
    int n_vec = 0;
    int n_bad = 0;

    wire [EW-1:0] obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                         memwb_en, memwb_flush, halt, stall_cnt};

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .mem_req(mem_req), .dhit(dhit), .redirect(redirect),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic ih, input logic mr, input logic dh, input logic rd,
                                input logic em, input logic [4:0] erd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic wh, input logic [8:0] ctl,
                                input logic h, input int cnt);
        vec_t v;
        v.ihit = ih; v.mem_req = mr; v.dhit = dh; v.redirect = rd; v.ex_memread = em;
        v.ex_rd = erd; v.id_rs1 = r1; v.id_rs2 = r2; v.wb_halt = wh;
        v.exp = {ctl, h, cnt[CNT_W-1:0]};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        ihit = v.ihit; mem_req = v.mem_req; dhit = v.dhit; redirect = v.redirect;
        ex_memread = v.ex_memread; ex_rd = v.ex_rd; id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
        wb_halt = v.wb_halt;
        sb.push_back(v.exp);
    endtask

    task automatic test_reset;
        vec_t tbl[$];
        logic [EW-1:0] e;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 0));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            nRST = (i == 0) ? 1'b0 : 1'b1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_dstall;
        vec_t tbl[$];
        logic [EW-1:0] e;
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, C_DSTALL, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, C_DSTALL, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, C_DSTALL, 0, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, C_NORM, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 3));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL dstall[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use;
        vec_t tbl[$];
        logic [EW-1:0] e;
        tbl.push_back(mk(1, 0, 0, 0, 1, 5, 0, 5, 0, C_LUSE, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, C_NORM, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 7, 7, 2, 0, C_LUSE, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 7, 6, 8, 0, C_NORM, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 7, 7, 0, C_NORM, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_FETCH, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 9, 9, 0, 0, C_LUSE, 0, 3));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_redirect;
        vec_t tbl[$];
        logic [EW-1:0] e;
        tbl.push_back(mk(0, 0, 0, 1, 1, 3, 3, 0, 0, C_REDIR, 0, 3));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, C_DSTALL, 0, 3));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, C_REDIR, 0, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 4));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL redirect[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_halt;
        vec_t tbl[$];
        logic [EW-1:0] e;
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_ZERO, 0, 4));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 1, 4));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, C_ZERO, 1, 4));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_ZERO, 1, 4));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL halt[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    task automatic test_saturate;
        vec_t tbl[$];
        logic [EW-1:0] e;
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, C_DSTALL, 0, (k > 7) ? 7 : k));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, C_NORM, 0, 7));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0, 7));
        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            drive(tbl[i]);
            @(negedge CLK);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got %b expected %b", i, obs, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_dstall;
        test_load_use;
        test_redirect;
        test_halt;
        test_reset;
        test_saturate;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
